// File: rtl/frac_mc.sv
// frac_mc: fractional motion compensator, 4-read bilinear interpolation of a BLKxBLK block streamed over valid/ready
module frac_mc #(
  parameter int STRIDE = 16,
  parameter int BLK = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] pix_pos,
  input  logic [3:0]    frac_idx,
  output logic          busy,
  output logic          ref_rd,
  output logic [AW-1:0] ref_addr,
  input  logic [7:0]    ref_data,
  output logic          pred_valid,
  input  logic          pred_ready,
  output logic [7:0]    pred_data,
  output logic          pred_last,
  output logic          done,
  output logic          err
);
  localparam int CW = $clog2(BLK);
  typedef enum logic [2:0] {IDLE, FETCH, CALC, OUT, FIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] pos, ox, oy, ox_n, oy_n, base;
  logic [CW-1:0] r, c;
  logic [1:0]    ph;
  logic [7:0]    pa, pb, pc;
  logic [9:0]    sum;
  logic          accept, last;
  assign accept = state == IDLE && start && frac_idx <= 4'd8;
  assign last   = r == CW'(BLK - 1) && c == CW'(BLK - 1);
  assign base   = pos + AW'(STRIDE * r) + AW'(c);
  assign sum    = 10'(pa) + 10'(pb) + 10'(pc) + 10'(ref_data) + 10'd2;
  // horizontal/vertical neighbour offsets for the requested candidate, as modulo-2**AW address deltas
  always_comb begin
    ox_n = (frac_idx == 4'd0 || frac_idx == 4'd3 || frac_idx == 4'd6) ? '1 :
           (frac_idx == 4'd2 || frac_idx == 4'd5 || frac_idx == 4'd8) ? AW'(1) : '0;
    oy_n = frac_idx < 4'd3 ? '0 - AW'(STRIDE) : frac_idx > 4'd5 ? AW'(STRIDE) : '0;
  end
  // next state and the state-decoded outputs; the four reads walk A, B, C, D
  always_comb begin
    state_n  = state;
    busy     = state != IDLE;
    ref_rd   = state == FETCH;
    ref_addr = ref_rd ? base + (ph[0] ? ox : '0) + (ph[1] ? oy : '0) : '0;
    done     = state == FIN;
    case (state)
      IDLE:    state_n = accept ? FETCH : IDLE;
      FETCH:   state_n = ph == 2'd3 ? CALC : FETCH;
      CALC:    state_n = OUT;
      OUT:     state_n = pred_ready ? (pred_last ? FIN : FETCH) : OUT;
      default: state_n = IDLE;
    endcase
  end
  // state, latched request, read-data capture and the registered output pel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pos        <= '0;
      ox         <= '0;
      oy         <= '0;
      r          <= '0;
      c          <= '0;
      ph         <= '0;
      pa         <= '0;
      pb         <= '0;
      pc         <= '0;
      pred_valid <= 1'b0;
      pred_data  <= '0;
      pred_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      err   <= state == IDLE && start && frac_idx > 4'd8;
      if (accept) begin
        pos <= pix_pos;
        ox  <= ox_n;
        oy  <= oy_n;
        r   <= '0;
        c   <= '0;
        ph  <= '0;
      end
      if (state == FETCH) begin
        ph <= ph + 2'd1;
        if (ph == 2'd1) pa <= ref_data;
        if (ph == 2'd2) pb <= ref_data;
        if (ph == 2'd3) pc <= ref_data;
      end
      if (state == CALC) begin
        pred_valid <= 1'b1;
        pred_data  <= sum[9:2];
        pred_last  <= last;
      end
      if (state == OUT && pred_ready) begin
        pred_valid <= 1'b0;
        pred_last  <= 1'b0;
        {r, c}     <= {r, c} + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frac_mc.sv
// tb_frac_mc: directed checks of frac_mc against a behavioural interpolation model
module tb_frac_mc;
  logic       clk = 0, rst = 0, start = 0, pred_ready = 0;
  logic [7:0] pix_pos = 0, ref_addr, ref_data = 0, pred_data;
  logic [3:0] frac_idx = 0;
  logic       busy, ref_rd, pred_valid, pred_last, done, err;
  logic [7:0] mem [256];
  logic [7:0] addrs [$];
  int n_chk = 0, n_fail = 0, done_cnt = 0, rd_cnt = 0;
  logic [7:0] first;
  frac_mc dut (
    .clk(clk), .rst(rst), .start(start), .pix_pos(pix_pos), .frac_idx(frac_idx),
    .busy(busy), .ref_rd(ref_rd), .ref_addr(ref_addr), .ref_data(ref_data),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data),
    .pred_last(pred_last), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  // reference memory with one cycle read latency
  always @(posedge clk) if (ref_rd) ref_data <= mem[ref_addr];
  // event monitors sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (ref_rd) begin
      rd_cnt++;
      addrs.push_back(ref_addr);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [7:0] p, input logic [3:0] k, input int i);
    int kk = int'(k), r = i / 4, c = i % 4, dx, dy, a, s;
    dx = kk % 3 - 1;
    dy = kk / 3 - 1;
    a = int'(p) + 16 * r + c;
    s = mem[a & 255] + mem[(a + dx) & 255] + mem[(a + 16 * dy) & 255] + mem[(a + dx + 16 * dy) & 255];
    return 8'((s + 2) >> 2);
  endfunction
  task automatic run_block(input logic [7:0] p, input logic [3:0] k, input int rp, input int npel, input bit poke);
    int idx = 0, cyc = 0, d0;
    bit held = 0;
    logic [7:0] hdata = 0;
    d0 = done_cnt;
    @(negedge clk);
    pix_pos = p;
    frac_idx = k;
    start = 1;
    @(negedge clk);
    start = 0;
    pix_pos = 8'($urandom);
    frac_idx = 4'($urandom);
    while (idx < npel && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 20) begin
        start = 1;
        pix_pos = 8'h00;
        frac_idx = 4'd4;
      end
      if (cyc == 21) start = 0;
      if (held) begin
        check("hold_valid", pred_valid, 1);
        check("hold_data", pred_data, hdata);
      end
      if (pred_valid) begin
        pred_ready = $urandom_range(0, 99) < rp;
        if (pred_ready) begin
          if (idx == 0) first = pred_data;
          check($sformatf("pel%0d", idx), pred_data, model(p, k, idx));
          check($sformatf("last%0d", idx), pred_last, idx == 15);
          idx++;
          held = 0;
        end else begin
          held = 1;
          hdata = pred_data;
        end
      end else pred_ready = 1'($urandom_range(0, 1));
    end
    check("pel_count", idx, npel);
    @(negedge clk);
    pred_ready = 0;
    if (npel == 16) begin
      repeat (3) @(negedge clk);
      check("done_once", done_cnt - d0, 1);
      check("busy_end", busy, 0);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd"}, ref_rd, 0);
    check({tag, "_addr"}, ref_addr, 0);
    check({tag, "_valid"}, pred_valid, 0);
    check({tag, "_data"}, pred_data, 0);
    check({tag, "_last"}, pred_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask
  initial begin
    int r0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1;
    @(negedge clk);
    run_block(8'h22, 4'd4, 100, 16, 0);
    check("k4_first", first, 8'h22);
    run_block(8'h22, 4'd5, 100, 16, 1);
    check("k5_first", first, 8'h23);
    run_block(8'h22, 4'd0, 60, 16, 0);
    check("k0_first", first, 8'h1A);
    addrs.delete();
    r0 = rd_cnt;
    run_block(8'hFE, 4'd8, 100, 16, 0);
    check("wrap_first", first, 8'h87);
    check("wrap_a0", addrs[0], 8'hFE);
    check("wrap_a1", addrs[1], 8'hFF);
    check("wrap_a2", addrs[2], 8'h0E);
    check("wrap_a3", addrs[3], 8'h0F);
    check("wrap_reads", rd_cnt - r0, 64);
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      run_block(8'($urandom), 4'(k), 50, 16, 0);
      check($sformatf("ff_k%0d", k), first, 8'hFF);
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    r0 = rd_cnt;
    foreach (addrs[i]) ;
    for (int k = 9; k < 16; k += 6) begin
      @(negedge clk);
      frac_idx = 4'(k);
      start = 1;
      @(negedge clk);
      start = 0;
      check($sformatf("err_pulse%0d", k), err, 1);
      check($sformatf("err_busy%0d", k), busy, 0);
      @(negedge clk);
      check($sformatf("err_clear%0d", k), err, 0);
      check($sformatf("err_reads%0d", k), rd_cnt - r0, 0);
    end
    run_block(8'h22, 4'd1, 100, 5, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst = 1;
    run_block(8'h22, 4'd7, 70, 16, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
